fetch_prefetch_buffer: RTL
==========================

// Module: fetch_prefetch_buffer
// PURPOSE
//  Instruction prefetch queue between the RV32E core fetch port and the instruction cache CPU side.
//  Runs ahead of the core on a sequential PC, pulling one word per cache-ready cycle.
//  Buffers up to DEPTH {pc, instr} pairs, so i-cache hit latency and refill stalls are hidden from decode.
//  On a core redirect (branch/jump from ID or EX): flushes the queue, aborts the cache access, restarts at the new PC.
// PARAMETERS
//  DEPTH      4       queue entries; power of 2, >= 2
//  RESET_PC   32'h0   unused when boot_addr is driven; kept for standalone benches
// PORTS
//  clk            in   1   single clock (same as HCLK); all logic on rising edge
//  rst            in   1   synchronous, active-high reset
//  boot_addr      in   32  first fetch PC after reset; sampled in BOOT
//  redirect_valid in   1   core redirect (pc_load_id | pc_load_ex)
//  redirect_pc    in   32  redirect target; bits[1:0] forced to 0 internally
//  cache_req      out  1   fetch request valid to i-cache
//  cache_addr     out  32  fetch address; held stable while cache_req=1 and cache_ready=0
//  cache_abort    out  1   one-cycle pulse: cache drops any in-flight fill for the old address
//  cache_ready    in   1   cache_data valid for cache_addr in this cycle
//  cache_data     in   32  instruction word
//  fetch_valid    out  1   queue head valid
//  fetch_pc       out  32  PC of head entry
//  fetch_instr    out  32  instruction of head entry
//  fetch_take     in   1   core consumes head this cycle (honoured only if fetch_valid=1)
//  occupancy      out  $clog2(DEPTH)+1  entries held (debug/perf)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=BOOT, queue empty.
//   Outputs: cache_req=0, cache_abort=0, fetch_valid=0, occupancy=0, cache_addr=0.
//  FSM states BOOT / FETCH / FLUSH.
//   BOOT:  next_pc<=boot_addr&~3; ->FETCH. cache_req=0.
//   FETCH: cache_req=1 iff push permitted (occupancy<DEPTH, or occupancy==DEPTH with fetch_take=1).
//          cache_addr=next_pc.
//          push = cache_req & cache_ready: enqueue {next_pc, cache_data}; next_pc<=next_pc+4
//          (32-bit wrap, 0xFFFF_FFFC -> 0x0).
//   FLUSH: entered on redirect_valid from any state but BOOT; one cycle.
//          cache_req=0, cache_abort=1; ->FETCH.
//  Redirect (redirect_valid=1 in FETCH or FLUSH):
//   - queue cleared and next_pc<=redirect_pc&~3 at that edge; ->FLUSH
//   - cache response in the same cycle discarded; fetch_take ignored
//   - redirect in FLUSH re-arms FLUSH with the newer PC
//   - redirect in BOOT ignored
//  Queue:
//   - fetch_valid = occupancy!=0; head registered, no cache->core bypass
//   - latency cache_ready -> fetch_valid = 1 cycle
//   - simultaneous push+pop: occupancy unchanged; push when full only with pop
//   - pop when empty is a no-op (no underflow); pointers wrap modulo DEPTH
//  Timing: after redirect at edge N, cache_abort=1 in cycle N+1, cache_req=1 with new addr in cycle N+2.
//   First new instruction visible at earliest cycle N+3.
//  Sustained throughput: 1 instr/cycle when cache_ready=1 every cycle and core takes every cycle.
//  cache_addr must not change while cache_req=1 & cache_ready=0 (holds through full stall and miss).
//  rst mid-fill: queue dropped, state BOOT; cache_abort is not asserted (cache resets itself).
// STRUCTURE
//  fetch_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t;
//   typedef enum logic [1:0] {BOOT, FETCH, FLUSH} fetch_state_t; localparam INSTR_BYTES=4.
//  Sub-module fetch_fifo #(DEPTH, type T=fetch_entry_t): sync FIFO with push/pop/clear, full/empty/count.
//   Clear has priority over push/pop.
//  Top holds FSM, next_pc counter, request/abort logic.
// TESTING
//  1 Reset: boot_addr=0x100, cache_ready=1 always, core takes every cycle
//    -> fetch_pc sequence 0x100,0x104,0x108...; first fetch_valid 2 cycles after BOOT.
//  2 Fill to full: fetch_take=0, cache_ready=1 -> 4 pushes, occupancy=4, cache_req=0, cache_addr=0x110 held.
//    One take -> exactly one more push (pc 0x110).
//  3 Miss stall: cache_ready=0 for 10 cycles at 0x108 -> cache_addr stable at 0x108.
//    Queue drains to 0 and fetch_valid=0 without underflow.
//  4 Redirect mid-stream: occupancy=3, redirect_valid=1, redirect_pc=0x2002
//    -> occupancy=0 next cycle, cache_abort one pulse, next cache_addr=0x2000, next fetch_pc=0x2000.
//  5 Back-to-back redirects 0x300 then 0x400 on consecutive cycles
//    -> no entry from 0x300 ever becomes visible; fetch resumes at 0x400.
//  6 Redirect with same-cycle cache_ready and fetch_take -> neither response enqueued nor pop counted.
//    Address wrap 0xFFFFFFFC -> 0x0 enqueues correctly.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction prefetch path.
// Holds the queue entry layout, FSM states and the instruction size.
package fetch_pkg;

   localparam int INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      FLUSH
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear; clear beats push and pop.
// Ports: clk, rst, clear, push, data_in, pop, data_out, full, empty, count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  T                         data_in,
   input  logic                     pop,
   output T                         data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   T                mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [CW-1:0]   cnt;
   logic            do_push;
   logic            do_pop;

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign data_out = mem[rd_ptr];

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!rst && !clear && do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            cnt <= cnt + 1'b1;
         end else if (do_pop && !do_push) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Prefetch queue between the core fetch port and the i-cache CPU side.
// Ports: clk, rst, boot_addr, redirect_*, cache_*, fetch_*, occupancy.
module fetch_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             boot_addr,
   input  logic                    redirect_valid,
   input  logic [31:0]             redirect_pc,
   output logic                    cache_req,
   output logic [31:0]             cache_addr,
   output logic                    cache_abort,
   input  logic                    cache_ready,
   input  logic [31:0]             cache_data,
   output logic                    fetch_valid,
   output logic [31:0]             fetch_pc,
   output logic [31:0]             fetch_instr,
   input  logic                    fetch_take,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam logic [31:0] PC_MASK = ~32'h3;

   fetch_state_t  state_q;
   fetch_state_t  state_d;
   logic [31:0]   pc_q;
   logic [31:0]   pc_d;
   logic          push;
   logic          pop;
   logic          clear;
   logic          full;
   logic          empty;
   fetch_entry_t  head;
   fetch_entry_t  entry_in;

   assign entry_in    = '{pc: pc_q, instr: cache_data};
   assign cache_addr  = pc_q;
   assign fetch_valid = ~empty;
   assign fetch_pc    = head.pc;
   assign fetch_instr = head.instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC & PC_MASK;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cache_req   = 1'b0;
      cache_abort = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      clear       = 1'b0;
      unique case (state_q)
         BOOT: begin
            pc_d    = boot_addr & PC_MASK;
            state_d = FETCH;
         end
         FETCH: begin
            // Full only frees a slot when the core takes the head now.
            cache_req = ~full | fetch_take;
            push      = cache_req & cache_ready;
            pop       = fetch_take & ~empty;
            if (push) begin
               pc_d = pc_q + 32'(INSTR_BYTES);
            end
         end
         FLUSH: begin
            cache_abort = 1'b1;
            state_d     = FETCH;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      // Redirect wins: drop the same-cycle response and any pop.
      if (redirect_valid && state_q != BOOT) begin
         clear   = 1'b1;
         push    = 1'b0;
         pop     = 1'b0;
         pc_d    = redirect_pc & PC_MASK;
         state_d = FLUSH;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .push     (push),
      .data_in  (entry_in),
      .pop      (pop),
      .data_out (head),
      .full     (full),
      .empty    (empty),
      .count    (occupancy)
   );

endmodule
